// File: rtl/kgp_mem_pkg.sv
// rtl/kgp_mem_pkg.sv - shared owner encoding, default widths and in-flight tag type
package kgp_mem_pkg;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

endpackage

// File: rtl/kgp_mem_arbiter_if.sv
// rtl/kgp_mem_arbiter_if.sv - fetch, data and BRAM signal bundle for the memory arbiter
interface kgp_mem_arbiter_if
  import kgp_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_dout,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_din
  );

  modport master (
    output if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_dout,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_din
  );

endinterface

// File: rtl/kgp_rd_tag_pipe.sv
// rtl/kgp_rd_tag_pipe.sv - READ_LAT-deep {valid, owner} shift register with fetch flush
module kgp_rd_tag_pipe
  import kgp_mem_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t i_push,
  input  logic    i_flush_if,
  output rd_tag_t o_tail
);

  rd_tag_t r_pipe [READ_LAT];
  rd_tag_t w_next [READ_LAT];

  // Flush applies to the entry entering this cycle as well as those already queued.
  always_comb begin
    w_next[0] = i_push;
    for (int i = 1; i < READ_LAT; i++) begin
      w_next[i] = r_pipe[i-1];
    end
    for (int i = 0; i < READ_LAT; i++) begin
      if (i_flush_if && (w_next[i].owner == OWN_IF)) begin
        w_next[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LAT; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      for (int i = 0; i < READ_LAT; i++) begin
        r_pipe[i] <= w_next[i];
      end
    end
  end

  // A fetch return landing in the flush cycle is stale too, so it is masked.
  assign o_tail.owner = r_pipe[READ_LAT-1].owner;
  assign o_tail.valid = r_pipe[READ_LAT-1].valid &
                        ~(i_flush_if & (r_pipe[READ_LAT-1].owner == OWN_IF));

endmodule

// File: rtl/kgp_mem_arbiter.sv
// rtl/kgp_mem_arbiter.sv - shares one registered-read BRAM between fetch and data ports
module kgp_mem_arbiter
  import kgp_mem_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int READ_LAT      = 1,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  kgp_mem_arbiter_if.slave  bus
);

  localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  logic [STREAK_W-1:0] r_streak;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_dm_rdata;

  logic                w_streak_full;
  logic                w_if_gnt;
  logic                w_dm_gnt;
  logic                w_store;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic                w_if_rvalid;
  logic                w_dm_rvalid;
  rd_tag_t             w_push;
  rd_tag_t             w_tail;

  // Data wins ties until it has starved a waiting fetch MAX_DM_STREAK times.
  assign w_streak_full = (r_streak == STREAK_MAX);
  assign w_if_gnt      = reset & bus.if_req & (~bus.dm_req | w_streak_full);
  assign w_dm_gnt      = reset & bus.dm_req & ~(bus.if_req & w_streak_full);
  assign w_store       = w_dm_gnt & bus.dm_we;
  assign w_mem_addr    = w_dm_gnt ? bus.dm_addr : bus.if_addr;

  assign bus.if_gnt   = w_if_gnt;
  assign bus.dm_gnt   = w_dm_gnt;
  assign bus.mem_en   = w_if_gnt | w_dm_gnt;
  assign bus.mem_we   = w_store;
  assign bus.mem_addr = w_mem_addr;
  assign bus.mem_din  = w_store ? bus.dm_wdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_streak <= '0;
    end else if (w_if_gnt || !bus.if_req) begin
      r_streak <= '0;
    end else if (w_dm_gnt && !w_streak_full) begin
      r_streak <= r_streak + 1'b1;
    end
  end

  assign w_push.valid = w_if_gnt | (w_dm_gnt & ~bus.dm_we);
  assign w_push.owner = w_dm_gnt ? OWN_DM : OWN_IF;

  kgp_rd_tag_pipe #(
    .READ_LAT (READ_LAT)
  ) u_tag_pipe (
    .clk        (clk),
    .rst_n      (reset),
    .i_push     (w_push),
    .i_flush_if (bus.if_flush),
    .o_tail     (w_tail)
  );

  assign w_if_rvalid = w_tail.valid & (w_tail.owner == OWN_IF);
  assign w_dm_rvalid = w_tail.valid & (w_tail.owner == OWN_DM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      if (w_if_rvalid) r_if_rdata <= bus.mem_dout;
      if (w_dm_rvalid) r_dm_rdata <= bus.mem_dout;
    end
  end

  assign bus.if_rvalid = w_if_rvalid;
  assign bus.dm_rvalid = w_dm_rvalid;
  assign bus.if_rdata  = w_if_rvalid ? bus.mem_dout : r_if_rdata;
  assign bus.dm_rdata  = w_dm_rvalid ? bus.mem_dout : r_dm_rdata;

endmodule

// File: tb/tb_kgp_mem_arbiter.sv
// tb/tb_kgp_mem_arbiter.sv - scoreboard bench driving READ_LAT=1 and READ_LAT=2 arbiters in lockstep
module tb_kgp_mem_arbiter;
  import kgp_mem_pkg::*;

  localparam int MAX_STREAK = 4;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        d_if_req, d_if_flush, d_dm_req, d_dm_we;
  logic [9:0]  d_if_addr, d_dm_addr;
  logic [31:0] d_dm_wdata;

  kgp_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus1 ();
  kgp_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus2 ();

  assign bus1.if_req = d_if_req;   assign bus2.if_req = d_if_req;
  assign bus1.if_addr = d_if_addr; assign bus2.if_addr = d_if_addr;
  assign bus1.if_flush = d_if_flush; assign bus2.if_flush = d_if_flush;
  assign bus1.dm_req = d_dm_req;   assign bus2.dm_req = d_dm_req;
  assign bus1.dm_we = d_dm_we;     assign bus2.dm_we = d_dm_we;
  assign bus1.dm_addr = d_dm_addr; assign bus2.dm_addr = d_dm_addr;
  assign bus1.dm_wdata = d_dm_wdata; assign bus2.dm_wdata = d_dm_wdata;

  kgp_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .READ_LAT(1), .MAX_DM_STREAK(MAX_STREAK))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));
  kgp_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .READ_LAT(2), .MAX_DM_STREAK(MAX_STREAK))
    dut2 (.clk(clk), .reset(reset), .bus(bus2));

  // Write-first BRAM models, preloaded with 0xA0+addr while reset is low.
  logic [31:0] bram1 [1024];
  logic [31:0] bram2 [1024];
  logic [31:0] rd1_q, rd2_q0, rd2_q1;

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 1024; i++) bram1[i] <= 32'hA0 + 32'(i);
    end else if (bus1.mem_en) begin
      if (bus1.mem_we) begin
        bram1[bus1.mem_addr] <= bus1.mem_din;
        rd1_q <= bus1.mem_din;
      end else begin
        rd1_q <= bram1[bus1.mem_addr];
      end
    end
  end

  always @(posedge clk) begin
    rd2_q1 <= rd2_q0;
    if (!reset) begin
      for (int i = 0; i < 1024; i++) bram2[i] <= 32'hA0 + 32'(i);
    end else if (bus2.mem_en) begin
      if (bus2.mem_we) begin
        bram2[bus2.mem_addr] <= bus2.mem_din;
        rd2_q0 <= bus2.mem_din;
      end else begin
        rd2_q0 <= bram2[bus2.mem_addr];
      end
    end
  end

  assign bus1.mem_dout = rd1_q;
  assign bus2.mem_dout = rd2_q1;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          ms = 0;
  logic [31:0] exp_mem [1024];
  logic [31:0] gnt_hist = '0;
  exp_t        q_if1[$], q_dm1[$], q_if2[$], q_dm2[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=0x%08h expected=0x%08h", tag, cyc, obs, exp);
    end
  endtask

  task automatic init_model();
    for (int i = 0; i < 1024; i++) exp_mem[i] = 32'hA0 + 32'(i);
    q_if1.delete(); q_dm1.delete(); q_if2.delete(); q_dm2.delete();
    ms = 0;
  endtask

  task automatic check_returns();
    logic v;
    v = (q_if1.size() > 0) && (q_if1[0].due == cyc);
    check_eq("if1_rvalid", bus1.if_rvalid, v);
    if (v) begin check_eq("if1_rdata", bus1.if_rdata, q_if1[0].data); void'(q_if1.pop_front()); end
    v = (q_dm1.size() > 0) && (q_dm1[0].due == cyc);
    check_eq("dm1_rvalid", bus1.dm_rvalid, v);
    if (v) begin check_eq("dm1_rdata", bus1.dm_rdata, q_dm1[0].data); void'(q_dm1.pop_front()); end
    v = (q_if2.size() > 0) && (q_if2[0].due == cyc);
    check_eq("if2_rvalid", bus2.if_rvalid, v);
    if (v) begin check_eq("if2_rdata", bus2.if_rdata, q_if2[0].data); void'(q_if2.pop_front()); end
    v = (q_dm2.size() > 0) && (q_dm2[0].due == cyc);
    check_eq("dm2_rvalid", bus2.dm_rvalid, v);
    if (v) begin check_eq("dm2_rdata", bus2.dm_rdata, q_dm2[0].data); void'(q_dm2.pop_front()); end
  endtask

  task automatic step(input logic ir, input logic [9:0] ia, input logic fl,
                      input logic dr, input logic dw, input logic [9:0] da,
                      input logic [31:0] wd);
    logic full, e_if, e_dm, e_st;
    d_if_req = ir; d_if_addr = ia; d_if_flush = fl;
    d_dm_req = dr; d_dm_we = dw; d_dm_addr = da; d_dm_wdata = wd;
    @(negedge clk);
    full = (ms == MAX_STREAK);
    e_if = ir && (!dr || full);
    e_dm = dr && !(ir && full);
    e_st = e_dm && dw;
    check_eq("if_gnt1", bus1.if_gnt, e_if);
    check_eq("dm_gnt1", bus1.dm_gnt, e_dm);
    check_eq("if_gnt2", bus2.if_gnt, e_if);
    check_eq("dm_gnt2", bus2.dm_gnt, e_dm);
    check_eq("mem_en", bus1.mem_en, e_if || e_dm);
    check_eq("mem_we", bus1.mem_we, e_st);
    check_eq("mem_din", bus1.mem_din, e_st ? wd : 32'h0);
    if (e_if || e_dm) check_eq("mem_addr", bus1.mem_addr, e_dm ? da : ia);
    gnt_hist = {gnt_hist[30:0], bus1.dm_gnt};
    if (fl) begin q_if1.delete(); q_if2.delete(); end
    check_returns();
    if (e_if && !fl) begin
      q_if1.push_back('{cyc + 1, exp_mem[ia]});
      q_if2.push_back('{cyc + 2, exp_mem[ia]});
    end
    if (e_dm) begin
      if (dw) exp_mem[da] = wd;
      else begin
        q_dm1.push_back('{cyc + 1, exp_mem[da]});
        q_dm2.push_back('{cyc + 2, exp_mem[da]});
      end
    end
    if (e_if || !ir) ms = 0;
    else if (e_dm && ms < MAX_STREAK) ms++;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic reset_step(input logic ir, input logic dr, input logic mid);
    d_if_req = ir; d_if_addr = 10'd3; d_if_flush = 1'b0;
    d_dm_req = dr; d_dm_we = 1'b0; d_dm_addr = 10'd4; d_dm_wdata = '0;
    if (mid) begin #2; reset = 1'b0; end
    @(negedge clk);
    init_model();
    check_eq("rst_if_gnt1", bus1.if_gnt, 1'b0);
    check_eq("rst_dm_gnt1", bus1.dm_gnt, 1'b0);
    check_eq("rst_mem_en1", bus1.mem_en, 1'b0);
    check_eq("rst_mem_en2", bus2.mem_en, 1'b0);
    check_eq("rst_if_rvalid1", bus1.if_rvalid, 1'b0);
    check_eq("rst_dm_rvalid1", bus1.dm_rvalid, 1'b0);
    check_eq("rst_if_rvalid2", bus2.if_rvalid, 1'b0);
    check_eq("rst_dm_rvalid2", bus2.dm_rvalid, 1'b0);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
  endtask

  initial begin
    d_if_req = 0; d_if_addr = 0; d_if_flush = 0;
    d_dm_req = 0; d_dm_we = 0; d_dm_addr = 0; d_dm_wdata = 0;
    init_model();
    @(posedge clk); #1;
    reset_step(1'b1, 1'b1, 1'b0);
    reset_step(1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    idle(1);

    for (int a = 0; a < 3; a++) step(1'b1, 10'(a), 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
    idle(3);

    gnt_hist = '0;
    for (int k = 0; k < 10; k++)
      step(1'b1, 10'(16 + k), 1'b0, 1'b1, 1'b0, 10'(32 + k), 32'h0);
    check_eq("dm_gnt_pattern", {22'h0, gnt_hist[9:0]}, 32'b1111011110);
    idle(3);

    step(1'b0, 10'd0, 1'b0, 1'b1, 1'b1, 10'd5, 32'hDEADBEEF);
    step(1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 10'd5, 32'h0);
    idle(3);

    step(1'b1, 10'd8, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
    step(1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 10'd9, 32'h0);
    idle(4);

    step(1'b1, 10'd40, 1'b0, 1'b1, 1'b0, 10'd50, 32'h0);
    step(1'b1, 10'd41, 1'b0, 1'b1, 1'b1, 10'd51, 32'h12345678);
    step(1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 10'd51, 32'h0);
    for (int k = 0; k < 6; k++)
      step(1'b1, 10'(42 + k), 1'b1 && (k == 2), 1'b1, 1'b0, 10'(60 + k), 32'h0);
    idle(3);

    step(1'b1, 10'd70, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
    reset_step(1'b1, 1'b0, 1'b1);
    reset_step(1'b1, 1'b0, 1'b0);
    reset_step(1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b1, 10'd71, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
    idle(3);

    for (int k = 0; k < 3; k++)
      step(1'b1, 10'd80, 1'b0, 1'b1, 1'b0, 10'(90 + k), 32'h0);
    reset_step(1'b1, 1'b1, 1'b1);
    reset_step(1'b1, 1'b1, 1'b0);
    reset_step(1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    gnt_hist = '0;
    for (int k = 0; k < 10; k++)
      step(1'b1, 10'(100 + k), 1'b0, 1'b1, 1'b0, 10'(120 + k), 32'h0);
    check_eq("dm_gnt_pattern_post_rst", {22'h0, gnt_hist[9:0]}, 32'b1111011110);
    idle(4);

    check_eq("queues_drained", 32'(q_if1.size() + q_dm1.size() + q_if2.size() + q_dm2.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kgp_mem_arbiter.md
Name: kgp_mem_arbiter

Overview:
- Shares the single-port block RAM (blk_mem_gen, registered read) between two KGP_RISC requesters: instruction fetch (if_*) and data load/store (dm_*).
- Issues at most one access per cycle and tracks in-flight reads so each read returns to its owner.
- Data wins ties; a starvation guard prevents data traffic from blocking fetch indefinitely.
- Sits between the KGP_RISC core and the memory macro.

Parameters:
- ADDR_W, 10, word-address width driven to the BRAM.
- DATA_W, 32, data word width.
- READ_LAT, 1, BRAM read latency in cycles, from mem_en to mem_dout valid. Legal range 1..3.
- MAX_DM_STREAK, 4, maximum consecutive data grants while if_req is waiting.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until granted.
- if_addr  in  ADDR_W  fetch word address.
- if_flush  in  1  discards all in-flight fetch returns (branch taken).
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  if_rdata valid, one-cycle pulse.
- if_rdata  out  DATA_W  fetched instruction.
- dm_req  in  1  data request; held until granted.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data word address.
- dm_wdata  in  DATA_W  store data.
- dm_gnt  out  1  data request accepted this cycle.
- dm_rvalid  out  1  dm_rdata valid, one-cycle pulse (loads only).
- dm_rdata  out  DATA_W  load data.
- mem_en  out  1  BRAM enable.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  ADDR_W  BRAM address.
- mem_din  out  DATA_W  BRAM write data.
- mem_dout  in  DATA_W  BRAM read data.

Behaviour:
- Reset (reset=0, asynchronous): streak counter=0, all in-flight tags cleared, if_rvalid=dm_rvalid=0.
- While reset is asserted, gnt/mem_en are forced 0. Reads in flight when reset asserts never produce rvalid.
- Grant is combinational in the same cycle as req. At most one gnt per cycle.
- mem_en = if_gnt|dm_gnt. mem_we = dm_gnt&dm_we. mem_addr/mem_din are muxed from the granted requester. mem_din = 0 when no store is granted.
- Priority when both req are high:
  - dm wins unless streak==MAX_DM_STREAK, in which case if wins.
- Streak counter:
  - increments on a dm grant while if_req=1;
  - clears on any if grant, or when if_req=0;
  - saturates at MAX_DM_STREAK.
- In-flight tracking: shift register of depth READ_LAT, one entry per cycle holding {valid, owner}.
  - Entry is pushed on a granted read (if read, or dm load). Stores push valid=0.
  - At the tail: if entry valid and owner=if, pulse if_rvalid and drive if_rdata=mem_dout. If owner=dm, pulse dm_rvalid and drive dm_rdata=mem_dout.
  - rdata outputs hold their last value when not valid.
- Latency: a read granted in cycle N gives rvalid in cycle N+READ_LAT. Throughput is one access per cycle, with no bubbles.
- if_flush=1: clears valid on every in-flight if-owned entry, including one granted in the same cycle. dm entries are unaffected. if_req is still arbitrated normally in the flush cycle.
- Store then load to the same address in back-to-back cycles returns the new data (BRAM write-first mode required).
- No requests: mem_en=0, streak clears, in-flight entries drain normally.
- Address wrap is the BRAM's own wrap; no range checking is done here.

Decomposition:
- Shared package kgp_mem_pkg holds:
  - owner encoding constants OWN_IF=1'b0, OWN_DM=1'b1;
  - default ADDR_W/DATA_W;
  - in-flight entry typedef {valid, owner}.
- One natural sub-module: kgp_rd_tag_pipe, the READ_LAT-deep {valid, owner} shift register with flush-by-owner, instantiated once.

Test Plan:
- Only if_req high, addresses 0,1,2 on consecutive cycles, BRAM preloaded with 0xA0+addr, READ_LAT=1 → if_gnt=1 in each cycle; if_rvalid in cycles +1..+3 with data 0xA0, 0xA1, 0xA2; dm_rvalid never asserts.
- Both req high continuously, MAX_DM_STREAK=4 → grant pattern dm,dm,dm,dm,if,dm,dm,dm,dm,if; each rvalid goes to the correct owner.
- Store dm_addr=5, wdata=0xDEADBEEF, then load addr 5 in the next cycle → mem_we=1 in the first cycle only; dm_rvalid one cycle after the load grant with dm_rdata=0xDEADBEEF; no rvalid for the store.
- READ_LAT=2: fetch addr 8 granted at N, load addr 9 granted at N+1, if_flush pulsed at N+1 → if_rvalid never asserts; dm_rvalid at N+3 with mem[9].
- Fetch reads granted at N and N+1, reset asserted asynchronously mid-cycle N+1, released at N+4 → no rvalid in any cycle from N+1 onward; streak=0; first grant after release behaves as from power-up.
